// File: rtl/cp0_trap_sequencer.sv
// cp0_trap_sequencer: sequences exception entry and ERET return around CP0.
module cp0_trap_sequencer #(
  parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic        instr_valid,
  input  logic        is_eret,
  input  logic [31:0] epc,
  input  logic        mem_busy,
  output logic        activeexception,
  output logic        eret,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] trap_count
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_MEM, S_FLUSH, S_COMMIT, S_VECTOR, S_ERET} state_t;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] epc_q;
  logic [15:0] count_q;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE:
        if (pendingexception && instr_valid) begin
          state_n = mem_busy ? S_WAIT_MEM : S_FLUSH;
          cnt_n = FLUSH_LOAD;
        end else if (is_eret && instr_valid) state_n = S_ERET;
      S_WAIT_MEM:
        if (!pendingexception) state_n = S_IDLE;
        else if (!mem_busy) begin
          state_n = S_FLUSH;
          cnt_n = FLUSH_LOAD;
        end
      S_FLUSH: begin
        state_n = (cnt == 4'd0) ? S_COMMIT : S_FLUSH;
        cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      S_COMMIT: state_n = S_VECTOR;
      default: state_n = S_IDLE;
    endcase
  end
  // epc keeps tracking while idle, so it holds the value from the IDLE->ERET edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      epc_q <= 32'h0;
      count_q <= 16'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == S_IDLE) epc_q <= epc;
      if (state == S_COMMIT) count_q <= count_q + 16'd1;
    end
  end
  assign activeexception = state == S_COMMIT;
  assign eret = state == S_ERET;
  assign flush = state == S_FLUSH || state == S_ERET;
  assign stall = state != S_IDLE;
  assign pc_redirect = state == S_VECTOR || state == S_ERET;
  assign redirect_pc = state == S_VECTOR ? VECTOR_ADDR : state == S_ERET ? epc_q : 32'h0;
  assign trap_count = count_q;
endmodule

// File: tb/tb_cp0_trap_sequencer.sv
// tb_cp0_trap_sequencer: scoreboard bench for the CP0 trap/ERET sequencer.
module tb_cp0_trap_sequencer;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'h8000_0180;
  typedef struct packed {
    logic ae, er, fl, st, pr;
    logic [31:0] rpc;
  } out_t;
  localparam out_t W = {5'b00010, 32'h0};
  localparam out_t F = {5'b00110, 32'h0};
  localparam out_t C = {5'b10010, 32'h0};
  localparam out_t V = {5'b00011, VEC};
  logic clk = 0, reset;
  logic pendingexception, instr_valid, is_eret, mem_busy;
  logic [31:0] epc;
  logic activeexception, eret, flush, stall, pc_redirect;
  logic [31:0] redirect_pc;
  logic [15:0] trap_count;
  out_t q[$];
  out_t act, exp_o;
  int n_cmp = 0, n_bad = 0;
  cp0_trap_sequencer #(.VECTOR_ADDR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .pendingexception(pendingexception),
    .instr_valid(instr_valid), .is_eret(is_eret), .epc(epc), .mem_busy(mem_busy),
    .activeexception(activeexception), .eret(eret), .flush(flush), .stall(stall),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .trap_count(trap_count)
  );
  always #5 clk = ~clk;
  assign act = {activeexception, eret, flush, stall, pc_redirect, redirect_pc};
  // Any non-idle output must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (activeexception | eret | flush | stall | pc_redirect)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %h required idle", act);
      end else begin
        exp_o = q.pop_front();
        if (act !== exp_o) begin
          n_bad++;
          $display("FAIL seq_output: got %h required %h", act, exp_o);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask
  task automatic trap(input int busy, input logic er);
    @(negedge clk);
    for (int i = 0; i < busy; i++) q.push_back(W);
    for (int i = 0; i < FC; i++) q.push_back(F);
    q.push_back(C);
    q.push_back(V);
    pendingexception = 1; instr_valid = 1; is_eret = er; mem_busy = busy > 0;
    @(negedge clk);
    instr_valid = 0; is_eret = 0;
    if (busy > 0) begin
      chk("wait_mem_flush_low", 64'(flush), 64'(0));
      repeat (busy - 1) @(negedge clk);
      mem_busy = 0;
      @(negedge clk);
      chk("flush_after_mem", 64'(flush), 64'(1));
      repeat (3) @(negedge clk);
    end else begin
      chk("flush_first_cycle", 64'(flush), 64'(1));
      repeat (4) @(negedge clk);
    end
    pendingexception = 0;
    @(negedge clk);
  endtask
  initial begin
    reset = 1; pendingexception = 0; instr_valid = 0; is_eret = 0; mem_busy = 0; epc = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(act), 64'(0));
    chk("reset_count", 64'(trap_count), 64'(0));
    reset = 0;
    repeat (2) @(negedge clk);
    trap(0, 0);
    chk("count_after_trap", 64'(trap_count), 64'(1));
    trap(5, 0);
    chk("count_after_memwait", 64'(trap_count), 64'(2));
    @(negedge clk);
    q.push_back(W); q.push_back(W);
    pendingexception = 1; instr_valid = 1; mem_busy = 1;
    @(negedge clk); instr_valid = 0;
    @(negedge clk); pendingexception = 0;
    @(negedge clk); mem_busy = 0;
    @(negedge clk);
    chk("withdraw_count", 64'(trap_count), 64'(2));
    q.push_back({5'b01111, 32'h0040_0020});
    epc = 32'h0040_0020; is_eret = 1; instr_valid = 1;
    @(negedge clk);
    is_eret = 0; instr_valid = 0; epc = 32'hdead_beef;
    repeat (2) @(negedge clk);
    chk("eret_count", 64'(trap_count), 64'(2));
    trap(0, 1);
    chk("both_count", 64'(trap_count), 64'(3));
    @(negedge clk);
    force dut.count_q = 16'hffff;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    chk("preload_count", 64'(trap_count), 64'(16'hffff));
    trap(0, 0);
    chk("count_wrap", 64'(trap_count), 64'(0));
    trap(0, 0);
    chk("count_after_wrap", 64'(trap_count), 64'(1));
    @(negedge clk);
    q.push_back(F);
    pendingexception = 1; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    @(posedge clk);
    #2 reset = 1;
    #1 chk("async_reset_outputs", 64'(act), 64'(0));
    chk("async_reset_count", 64'(trap_count), 64'(0));
    @(negedge clk);
    pendingexception = 0;
    reset = 0;
    repeat (8) @(negedge clk);
    chk("post_reset_count", 64'(trap_count), 64'(0));
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_output: got none required %h", exp_o);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cp0_trap_sequencer.md
Name: cp0_trap_sequencer

Overview:
Sequences exception entry and ERET return around the coprocessor 0 register file. It watches CP0's pendingexception and the commit-stage instruction boundary, drains outstanding memory, and flushes the pipeline. It then drives the single-cycle activeexception and eret pulses into CP0 and redirects the fetch PC to the trap vector or to EPC. It sits between CP0 and the pipeline hazard/PC-select logic.

Parameters:
VECTOR_ADDR, 32'h8000_0180, general exception vector loaded into fetch PC on trap entry
FLUSH_CYCLES, 2, cycles flush is held (legal range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pendingexception  in  1  CP0 exception/interrupt request (level)
instr_valid  in  1  valid instruction at commit boundary this cycle
is_eret  in  1  committing instruction is ERET (qualified by instr_valid)
epc  in  32  current CP0 EPC value
mem_busy  in  1  outstanding data-memory transaction
activeexception  out  1  one-cycle pulse to CP0: latch EPC/Cause, set EXL
eret  out  1  one-cycle pulse to CP0: clear EXL
flush  out  1  squash all pipeline stages younger than commit
stall  out  1  freeze fetch/decode/PC
pc_redirect  out  1  one-cycle: load redirect_pc into fetch PC
redirect_pc  out  32  target PC, valid when pc_redirect=1
trap_count  out  16  number of activeexception pulses since reset

Behaviour:
- One clock. Reset is asynchronous and active-high: clk and reset as named above. Reset forces state IDLE, flush counter 0, and trap_count 0. All outputs go to 0, including redirect_pc=32'h0.
- All outputs are registered (Moore, decoded from state). No combinational path from any input to any output.
- States: IDLE, WAIT_MEM, FLUSH, COMMIT, VECTOR, ERET.
- IDLE:
  - If pendingexception && instr_valid, go to WAIT_MEM when mem_busy=1, otherwise to FLUSH (counter loaded with FLUSH_CYCLES-1).
  - Else if is_eret && instr_valid, go to ERET.
  - The exception path wins when both the exception and ERET conditions are true in the same cycle.
  - pendingexception with instr_valid=0 waits in IDLE (traps are taken only at an instruction boundary).
- WAIT_MEM:
  - stall=1.
  - Go to FLUSH when mem_busy=0 and pendingexception=1.
  - If pendingexception drops (interrupt withdrawn), return to IDLE, no trap taken, and trap_count unchanged.
- FLUSH:
  - flush=1, stall=1.
  - The counter decrements each cycle. At 0, go to COMMIT.
  - flush is high for exactly FLUSH_CYCLES consecutive cycles.
  - Once FLUSH is entered, the trap is committed: pendingexception is ignored until the sequence returns to IDLE.
- COMMIT:
  - activeexception=1 and stall=1 for exactly one cycle.
  - trap_count increments by 1, mod 2^16 (0xFFFF wraps to 0x0000).
  - Go to VECTOR.
- VECTOR:
  - pc_redirect=1, redirect_pc=VECTOR_ADDR, stall=1 for one cycle.
  - Go to IDLE.
- ERET:
  - For one cycle: eret=1, flush=1, pc_redirect=1, redirect_pc=epc as sampled on the IDLE→ERET transition edge, stall=1.
  - Go to IDLE. trap_count is unchanged.
- Latency: the trigger is sampled at edge N with mem_busy=0. flush is high for cycles N+1..N+FLUSH_CYCLES. activeexception is high at N+FLUSH_CYCLES+1. pc_redirect is high at N+FLUSH_CYCLES+2.
- Back-to-back: the cycle after VECTOR or ERET is IDLE and may immediately accept a new trigger. There is a minimum 1 IDLE cycle between sequences.
- activeexception and eret are never high in the same cycle. pc_redirect is high only in VECTOR or ERET.
- Reset asserted mid-sequence immediately aborts to IDLE with all outputs 0. No partial pulse completes after reset deasserts.

Test Plan:
- Reset, then pendingexception=1 and instr_valid=1 with mem_busy=0 at edge 10 → flush high for cycles 11–12. activeexception is high only at 13. pc_redirect=1 with redirect_pc=0x80000180 at 14. trap_count=1. Back to IDLE at 15.
- Trigger with mem_busy=1 for 5 cycles → stall=1 and flush=0 during the wait. flush starts the cycle after mem_busy falls. Then deassert pendingexception during WAIT_MEM on a rerun → IDLE, and trap_count is unchanged.
- epc=0x00400020, is_eret=1, instr_valid=1 → next cycle eret=1, flush=1, pc_redirect=1, redirect_pc=0x00400020. activeexception=0 and trap_count is unchanged.
- pendingexception and is_eret both asserted with instr_valid=1 → exception sequence is taken (redirect to 0x80000180). eret is never pulsed.
- Preload 65535 traps (or force the counter) then one more trap → trap_count wraps 0xFFFF→0x0000.
- Assert reset during FLUSH (cycle 12 of the first scenario) → all outputs are 0 asynchronously. After release, there is no activeexception or pc_redirect unless retriggered.
